ps2_cmd_sequencer: RTL

//  Sits between the PS/2 byte receiver and the keyboard command decoder (sensor/silence/reset/enter keys).

---
 rtl/ps2_cmd_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 scan-code sequencer: filters the raw byte stream down to single make
// codes, queues them, and presents each one to the command decoder for a
// fixed hold time followed by an idle gap.
module ps2_cmd_sequencer #(
  parameter int         HOLD_CYCLES = 8,
  parameter int         GAP_CYCLES  = 8,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] IDLE_CODE   = 8'h00
) (
  input  logic       CLK_chaos,
  input  logic       restart,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] cmd_dato,
  output logic       cmd_active,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int MAX_C = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CTR_W = $clog2(MAX_C);
  localparam logic [PTR_W:0]   FULL_CNT = FIFO_DEPTH[PTR_W:0];
  localparam logic [CTR_W-1:0] HOLD_END = CTR_W'(HOLD_CYCLES - 1);
  localparam logic [CTR_W-1:0] GAP_END  = CTR_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {F_IDLE, F_BREAK, F_EXT} filt_e;
  typedef enum logic [1:0] {P_IDLE, P_HOLD, P_GAP} pres_e;

  filt_e            f_state_q, f_state_d;
  logic [7:0]       last_make_q, last_make_d;
  logic             push_q, push_d;
  logic [7:0]       push_data_q;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             fifo_full_q, overflow_q;
  logic             do_push, pop;
  logic [7:0]       head;

  pres_e            p_state_q, p_state_d;
  logic [CTR_W-1:0] cnt_q, cnt_d;
  logic [7:0]       dato_q, dato_d;
  logic             act_q, act_d;

  // Filter next state: classify each strobed byte as make, break or extended.
  always_comb begin
    f_state_d   = f_state_q;
    last_make_d = last_make_q;
    push_d      = 1'b0;
    if (rx_valid) begin
      case (f_state_q)
        F_IDLE: begin
          if (rx_data == 8'hF0) begin
            f_state_d = F_BREAK;
          end else if (rx_data == 8'hE0) begin
            f_state_d = F_EXT;
          end else if (rx_data != last_make_q) begin
            last_make_d = rx_data;
            push_d      = 1'b1;
          end
        end
        F_BREAK: begin
          if (rx_data == last_make_q) last_make_d = 8'h00;
          f_state_d = F_IDLE;
        end
        F_EXT: begin
          if (rx_data == 8'hF0) f_state_d = F_BREAK;
          else                  f_state_d = F_IDLE;
        end
        default: f_state_d = F_IDLE;
      endcase
    end
  end

  // Filter state and registered push request (the byte itself needs no reset).
  always_ff @(posedge CLK_chaos) begin
    push_data_q <= rx_data;
    if (restart) begin
      f_state_q   <= F_IDLE;
      last_make_q <= 8'h00;
      push_q      <= 1'b0;
    end else begin
      f_state_q   <= f_state_d;
      last_make_q <= last_make_d;
      push_q      <= push_d;
    end
  end

  // A push into a full queue only succeeds when the presenter frees a slot in the same cycle.
  assign do_push = push_q && ((count_q != FULL_CNT) || pop);
  assign head    = mem_q[rd_ptr_q];

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_d = count_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Queue storage: when full with a simultaneous pop, wr_ptr equals rd_ptr and
  // the head is read before being overwritten.
  always_ff @(posedge CLK_chaos) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_q;
  end

  // Queue pointers, occupancy and sticky overflow flag.
  always_ff @(posedge CLK_chaos) begin
    if (restart) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_full_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      fifo_full_q <= (count_d == FULL_CNT);
      if (push_q && !do_push) overflow_q <= 1'b1;
    end
  end

  // Presenter next state: hold each code, then an idle gap. A gap that ends
  // with work queued starts the next code immediately so the idle time is exact.
  always_comb begin
    p_state_d = p_state_q;
    cnt_d     = cnt_q;
    dato_d    = dato_q;
    act_d     = act_q;
    pop       = 1'b0;
    case (p_state_q)
      P_IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          dato_d    = head;
          act_d     = 1'b1;
          cnt_d     = '0;
          p_state_d = P_HOLD;
        end
      end
      P_HOLD: begin
        if (cnt_q == HOLD_END) begin
          dato_d    = IDLE_CODE;
          act_d     = 1'b0;
          cnt_d     = '0;
          p_state_d = P_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      P_GAP: begin
        if (cnt_q == GAP_END) begin
          cnt_d = '0;
          if (count_q != '0) begin
            pop       = 1'b1;
            dato_d    = head;
            act_d     = 1'b1;
            p_state_d = P_HOLD;
          end else begin
            p_state_d = P_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: p_state_d = P_IDLE;
    endcase
  end

  // Presenter state, counter and output registers.
  always_ff @(posedge CLK_chaos) begin
    if (restart) begin
      p_state_q <= P_IDLE;
      cnt_q     <= '0;
      dato_q    <= IDLE_CODE;
      act_q     <= 1'b0;
    end else begin
      p_state_q <= p_state_d;
      cnt_q     <= cnt_d;
      dato_q    <= dato_d;
      act_q     <= act_d;
    end
  end

  assign cmd_dato   = dato_q;
  assign cmd_active = act_q;
  assign fifo_full  = fifo_full_q;
  assign overflow   = overflow_q;

endmodule
